// File: rtl/mul_rs_sched.sv
// Allocation, oldest-ready issue and shadow pipeline control
// for the two-entry multiplier reservation station.
module mul_rs_sched #(
  parameter int ENT_NUM     = 2,
  parameter int ENT_SEL     = 1,
  parameter int MUL_LAT     = 3,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req1,
  input  logic                   req2,
  input  logic [ENT_NUM-1:0]     busyvec,
  input  logic [ENT_NUM-1:0]     readyvec,
  output logic                   alloc1,
  output logic                   alloc2,
  output logic [ENT_SEL-1:0]     allocent1,
  output logic [ENT_SEL-1:0]     allocent2,
  output logic                   alloc_stall,
  output logic                   issue_go,
  output logic [ENT_SEL-1:0]     issueaddr,
  input  logic [RRF_SEL-1:0]     iss_rrftag,
  input  logic                   iss_dstval,
  input  logic [SPECTAG_LEN-1:0] iss_spectag,
  input  logic                   iss_specbit,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic                   pipe_adv,
  output logic                   wb_req,
  output logic [RRF_SEL-1:0]     wb_rrftag,
  input  logic                   wb_grant
);

  localparam int CNT_W = ENT_SEL + 2;

  typedef struct packed {
    logic                   valid;
    logic                   dstval;
    logic [RRF_SEL-1:0]     rrftag;
    logic [SPECTAG_LEN-1:0] spectag;
    logic                   specbit;
  } stg_t;

  // ---------------- allocation ----------------
  logic [ENT_SEL-1:0] fr1;
  logic [ENT_SEL-1:0] fr2;
  logic               h1;
  logic               h2;
  logic [CNT_W-1:0]   nfree;
  logic [CNT_W-1:0]   nreq;
  logic               stall_c;

  always_comb begin
    fr1   = '0;
    fr2   = '0;
    h1    = 1'b0;
    h2    = 1'b0;
    nfree = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!busyvec[i]) begin
        nfree = nfree + CNT_W'(1);
        if (!h1) begin
          fr1 = ENT_SEL'(i);
          h1  = 1'b1;
        end else if (!h2) begin
          fr2 = ENT_SEL'(i);
          h2  = 1'b1;
        end
      end
    end
  end

  assign nreq    = CNT_W'(req1) + CNT_W'(req2);
  assign stall_c = (nfree < nreq) | prmiss | prsuccess;

  assign alloc_stall = stall_c & ~reset;
  assign alloc1      = req1 & ~stall_c & ~reset;
  assign alloc2      = req2 & ~stall_c & ~reset;
  assign allocent1   = reset ? '0 : fr1;
  assign allocent2   = reset ? '0 : (req1 ? fr2 : fr1);

  // ---------------- age matrix ----------------
  logic [ENT_NUM-1:0][ENT_NUM-1:0] older_q;
  logic [ENT_NUM-1:0][ENT_NUM-1:0] older_d;

  // slot 1 counts as already busy when slot 2 is written
  always_comb begin
    older_d = older_q;
    if (alloc1) begin
      older_d[allocent1] = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        if (busyvec[i]) older_d[i][allocent1] = 1'b1;
      end
    end
    if (alloc2) begin
      older_d[allocent2] = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        if (busyvec[i] || (alloc1 && ENT_SEL'(i) == allocent1))
          older_d[i][allocent2] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) older_q <= '0;
    else       older_q <= older_d;
  end

  // ---------------- issue select ----------------
  logic [ENT_NUM-1:0] cand;
  logic [ENT_SEL-1:0] sel;
  logic               found;
  logic               win;

  always_comb begin
    cand  = readyvec & busyvec;
    sel   = '0;
    found = 1'b0;
    win   = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      win = cand[i] & ~found;
      for (int j = 0; j < ENT_NUM; j++) begin
        if (j != i && cand[j] && !older_q[i][j]) win = 1'b0;
      end
      if (win) begin
        sel   = ENT_SEL'(i);
        found = 1'b1;
      end
    end
  end

  assign issue_go  = (|cand) & pipe_adv & ~prmiss;
  assign issueaddr = reset ? '0 : sel;

  // ---------------- shadow pipeline ----------------
  stg_t st_q [MUL_LAT];
  stg_t st_d [MUL_LAT];
  stg_t src  [MUL_LAT];

  function automatic stg_t spec_fix(
    input stg_t                   s,
    input logic                   miss,
    input logic                   succ,
    input logic [SPECTAG_LEN-1:0] ptag,
    input logic [SPECTAG_LEN-1:0] fix
  );
    stg_t r;
    r = s;
    if (miss) begin
      if (s.specbit && |(s.spectag & fix)) r.valid = 1'b0;
    end else if (succ && s.spectag == ptag) begin
      r.specbit = 1'b0;
    end
    return r;
  endfunction

  assign pipe_adv = ~reset & ~(st_q[MUL_LAT-1].valid &
                               st_q[MUL_LAT-1].dstval & ~wb_grant);

  always_comb begin
    src[0].valid   = issue_go;
    src[0].dstval  = iss_dstval;
    src[0].rrftag  = iss_rrftag;
    src[0].spectag = iss_spectag;
    src[0].specbit = iss_specbit;
    for (int k = 1; k < MUL_LAT; k++) src[k] = st_q[k-1];
    for (int k = 0; k < MUL_LAT; k++) begin
      st_d[k] = spec_fix(pipe_adv ? src[k] : st_q[k],
                         prmiss, prsuccess, prtag, specfixtag);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MUL_LAT; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < MUL_LAT; k++) st_q[k] <= st_d[k];
    end
  end

  assign wb_req    = ~reset & st_q[MUL_LAT-1].valid & st_q[MUL_LAT-1].dstval;
  assign wb_rrftag = (~reset & st_q[MUL_LAT-1].valid) ?
                     st_q[MUL_LAT-1].rrftag : '0;

endmodule

// File: tb/tb_mul_rs_sched.sv
// Bench for mul_rs_sched: allocation table, directed multi-cycle
// sequences, and a randomized run against a queue-based model.
module tb_mul_rs_sched;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req1, req2;
  logic [1:0] busyvec, readyvec;
  logic       alloc1, alloc2, alloc_stall;
  logic [0:0] allocent1, allocent2, issueaddr;
  logic       issue_go;
  logic [5:0] iss_rrftag;
  logic       iss_dstval;
  logic [4:0] iss_spectag;
  logic       iss_specbit;
  logic       prmiss, prsuccess;
  logic [4:0] prtag, specfixtag;
  logic       pipe_adv, wb_req;
  logic [5:0] wb_rrftag;
  logic       wb_grant;

  mul_rs_sched dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2),
    .busyvec(busyvec), .readyvec(readyvec),
    .alloc1(alloc1), .alloc2(alloc2),
    .allocent1(allocent1), .allocent2(allocent2),
    .alloc_stall(alloc_stall), .issue_go(issue_go),
    .issueaddr(issueaddr), .iss_rrftag(iss_rrftag),
    .iss_dstval(iss_dstval), .iss_spectag(iss_spectag),
    .iss_specbit(iss_specbit), .prmiss(prmiss),
    .prsuccess(prsuccess), .prtag(prtag),
    .specfixtag(specfixtag), .pipe_adv(pipe_adv),
    .wb_req(wb_req), .wb_rrftag(wb_rrftag), .wb_grant(wb_grant)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic clr_in();
    req1 = 0; req2 = 0; busyvec = 0; readyvec = 0;
    iss_rrftag = 0; iss_dstval = 0; iss_spectag = 0; iss_specbit = 0;
    prmiss = 0; prsuccess = 0; prtag = 0; specfixtag = 0;
    wb_grant = 0;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    clr_in();
    repeat (2) edge_();
    reset = 0;
  endtask

  task automatic set_iss(input logic [5:0] t, input logic d,
                         input logic [4:0] s, input logic b);
    iss_rrftag = t; iss_dstval = d; iss_spectag = s; iss_specbit = b;
  endtask

  // allocation vectors
  typedef struct {
    logic [1:0] busy;
    logic r1, r2, pm, ps;
    logic a1, a2, st;
    logic ce1, e1, ce2, e2;
  } avec_t;

  avec_t tv[$];

  function automatic avec_t mk(logic [1:0] b, logic r1, logic r2,
      logic pm, logic ps, logic a1, logic a2, logic st,
      logic ce1, logic e1, logic ce2, logic e2);
    avec_t v;
    v.busy = b; v.r1 = r1; v.r2 = r2; v.pm = pm; v.ps = ps;
    v.a1 = a1; v.a2 = a2; v.st = st;
    v.ce1 = ce1; v.e1 = e1; v.ce2 = ce2; v.e2 = e2;
    return v;
  endfunction

  // random-run model state
  typedef struct {
    logic [5:0] tag;
    bit         dst;
    logic [4:0] stg;
    bit         sb;
    int         pos;
  } op_t;

  op_t        fl_q[$];
  op_t        nq[$];
  op_t        o;
  bit         mb[2];
  int         sq[2];
  logic [5:0] mtag[2];
  bit         mdst[2];
  logic [4:0] mst[2];
  bit         msb[2];
  int         seqc;

  task automatic newent(input int e);
    mb[e]   = 1;
    sq[e]   = seqc++;
    mtag[e] = 6'($urandom_range(63));
    mdst[e] = 1'($urandom_range(1));
    mst[e]  = 5'(1 << $urandom_range(4));
    msb[e]  = 1'($urandom_range(1));
  endtask

  int  nf, fl0, fl1, need, fi, etag, best, addr, e2;
  bit  st, a1, a2, ewb, adv, go;

  initial begin
    clr_in();
    reset = 1;
    repeat (2) edge_();

    // outputs held at zero during reset
    req1 = 1; req2 = 1; readyvec = 2'b11; wb_grant = 1;
    #2;
    chk("rst_alloc1", 32'(alloc1), 0);
    chk("rst_alloc2", 32'(alloc2), 0);
    chk("rst_stall", 32'(alloc_stall), 0);
    chk("rst_go", 32'(issue_go), 0);
    chk("rst_adv", 32'(pipe_adv), 0);
    chk("rst_wbreq", 32'(wb_req), 0);
    chk("rst_wbtag", 32'(wb_rrftag), 0);
    reset = 0; readyvec = 0; wb_grant = 0;
    #2;
    chk("dual_a1", 32'(alloc1), 1);
    chk("dual_a2", 32'(alloc2), 1);
    chk("dual_e1", 32'(allocent1), 0);
    chk("dual_e2", 32'(allocent2), 1);
    chk("dual_st", 32'(alloc_stall), 0);
    edge_();
    clr_in();
    #2;
    chk("dual_nowb", 32'(wb_req), 0);

    // allocation table
    tv.push_back(mk(2'b00, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1));
    tv.push_back(mk(2'b01, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2'b01, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    tv.push_back(mk(2'b01, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(2'b10, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(2'b10, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tv.push_back(mk(2'b10, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2'b11, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(2'b00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2'b00, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2'b00, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < tv.size(); i++) begin
      do_reset();
      busyvec = tv[i].busy; req1 = tv[i].r1; req2 = tv[i].r2;
      prmiss = tv[i].pm; prsuccess = tv[i].ps;
      #2;
      chk($sformatf("tv%0d_a1", i), 32'(alloc1), 32'(tv[i].a1));
      chk($sformatf("tv%0d_a2", i), 32'(alloc2), 32'(tv[i].a2));
      chk($sformatf("tv%0d_st", i), 32'(alloc_stall), 32'(tv[i].st));
      if (tv[i].ce1)
        chk($sformatf("tv%0d_e1", i), 32'(allocent1), 32'(tv[i].e1));
      if (tv[i].ce2)
        chk($sformatf("tv%0d_e2", i), 32'(allocent2), 32'(tv[i].e2));
    end

    // age order and latency
    do_reset();
    req1 = 1; #2;
    chk("age_e1a", 32'(allocent1), 0);
    edge_();
    busyvec = 2'b01; #2;
    chk("age_e1b", 32'(allocent1), 1);
    edge_();
    req1 = 0; busyvec = 2'b11; readyvec = 2'b01;
    set_iss(6'h01, 0, 0, 0); #2;
    chk("age_go0", 32'(issue_go), 1);
    chk("age_ad0", 32'(issueaddr), 0);
    edge_();
    busyvec = 2'b10; readyvec = 0; req1 = 1; #2;
    chk("age_re0", 32'(allocent1), 0);
    edge_();
    req1 = 0; busyvec = 2'b11; readyvec = 2'b11;
    set_iss(6'h02, 0, 0, 0); #2;
    chk("age_old1", 32'(issueaddr), 1);
    chk("age_go1", 32'(issue_go), 1);
    edge_();
    busyvec = 2'b01; readyvec = 2'b01;
    set_iss(6'h15, 1, 0, 0); #2;
    chk("age_old0", 32'(issueaddr), 0);
    chk("age_go2", 32'(issue_go), 1);
    edge_();
    busyvec = 0; readyvec = 0; wb_grant = 1;
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk($sformatf("lat_req%0d", k), 32'(wb_req), (k == 3) ? 1 : 0);
      if (k == 3) chk("lat_tag", 32'(wb_rrftag), 32'h15);
      edge_();
    end
    #2;
    chk("lat_gone", 32'(wb_req), 0);

    // writeback backpressure
    do_reset();
    req1 = 1; edge_();
    req1 = 0; busyvec = 2'b01; readyvec = 2'b01;
    set_iss(6'h2A, 1, 0, 0); #2;
    chk("bp_go", 32'(issue_go), 1);
    edge_();
    busyvec = 0; readyvec = 0; req1 = 1; edge_();
    busyvec = 2'b01; req1 = 0; #2;
    chk("bp_early", 32'(wb_req), 0);
    edge_();
    readyvec = 2'b01; set_iss(6'h11, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("bp_adv%0d", k), 32'(pipe_adv), 0);
      chk($sformatf("bp_go%0d", k), 32'(issue_go), 0);
      chk($sformatf("bp_req%0d", k), 32'(wb_req), 1);
      chk($sformatf("bp_tag%0d", k), 32'(wb_rrftag), 32'h2A);
      edge_();
    end
    wb_grant = 1; #2;
    chk("bp_gadv", 32'(pipe_adv), 1);
    chk("bp_ggo", 32'(issue_go), 1);
    edge_();
    busyvec = 0; readyvec = 0; wb_grant = 0; #2;
    chk("bp_rel", 32'(wb_req), 0);
    edge_(); edge_();
    wb_grant = 1; #2;
    chk("bp_nreq", 32'(wb_req), 1);
    chk("bp_ntag", 32'(wb_rrftag), 32'h11);

    // mispredict kill
    do_reset();
    req1 = 1; req2 = 1; edge_();
    req1 = 0; req2 = 0; busyvec = 2'b11; readyvec = 2'b11;
    set_iss(6'h0A, 1, 5'b00100, 1); #2;
    chk("kill_ad0", 32'(issueaddr), 0);
    edge_();
    busyvec = 2'b10; readyvec = 2'b10;
    set_iss(6'h0B, 1, 5'b01000, 1); #2;
    chk("kill_ad1", 32'(issueaddr), 1);
    edge_();
    busyvec = 0; readyvec = 0; prmiss = 1; specfixtag = 5'b00110; #2;
    chk("kill_st", 32'(alloc_stall), 1);
    edge_();
    prmiss = 0; wb_grant = 1; #2;
    chk("kill_none", 32'(wb_req), 0);
    edge_(); #2;
    chk("kill_surv", 32'(wb_req), 1);
    chk("kill_stag", 32'(wb_rrftag), 32'h0B);
    edge_(); #2;
    chk("kill_done", 32'(wb_req), 0);

    // branch resolves correct, later mispredict spares the op
    do_reset();
    req1 = 1; edge_();
    req1 = 0; busyvec = 2'b01; readyvec = 2'b01;
    set_iss(6'h33, 1, 5'b00100, 1); edge_();
    busyvec = 0; readyvec = 0; prsuccess = 1; prtag = 5'b00100; edge_();
    prsuccess = 0; prmiss = 1; specfixtag = 5'b00100; edge_();
    prmiss = 0; wb_grant = 1; #2;
    chk("succ_req", 32'(wb_req), 1);
    chk("succ_tag", 32'(wb_rrftag), 32'h33);

    // reset mid-flight
    do_reset();
    req1 = 1; edge_();
    req1 = 0; busyvec = 2'b01; readyvec = 2'b01;
    set_iss(6'h3C, 1, 0, 0); edge_();
    busyvec = 0; readyvec = 0; reset = 1; #2;
    chk("mid_adv", 32'(pipe_adv), 0);
    edge_();
    reset = 0; wb_grant = 1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("mid_req%0d", k), 32'(wb_req), 0);
      edge_();
    end

    // randomized run
    do_reset();
    fl_q.delete();
    seqc = 0;
    for (int e = 0; e < 2; e++) begin
      mb[e] = 0; sq[e] = 0; mtag[e] = 0; mdst[e] = 0; mst[e] = 0; msb[e] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      req1 = 1'($urandom_range(1));
      req2 = 1'($urandom_range(1));
      readyvec = 2'($urandom_range(3));
      wb_grant = ($urandom_range(3) != 0);
      prmiss = ($urandom_range(11) == 0);
      prsuccess = ($urandom_range(9) == 0);
      prtag = 5'(1 << $urandom_range(4));
      specfixtag = 5'($urandom_range(31));
      busyvec = {mb[1], mb[0]};

      nf = 0; fl0 = 0; fl1 = 0;
      for (int e = 0; e < 2; e++) begin
        if (!mb[e]) begin
          if (nf == 0) fl0 = e;
          else fl1 = e;
          nf++;
        end
      end
      need = int'(req1) + int'(req2);
      st = (nf < need) || prmiss || prsuccess;
      a1 = req1 && !st;
      a2 = req2 && !st;
      e2 = req1 ? fl1 : fl0;
      fi = -1;
      foreach (fl_q[k]) if (fl_q[k].pos == L) fi = k;
      ewb  = (fi >= 0) && fl_q[fi].dst;
      etag = (fi >= 0) ? int'(fl_q[fi].tag) : 0;
      adv  = !(ewb && !wb_grant);
      best = -1;
      for (int e = 0; e < 2; e++)
        if (mb[e] && readyvec[e] && (best < 0 || sq[e] < sq[best])) best = e;
      go   = (best >= 0) && adv && !prmiss;
      addr = (best < 0) ? 0 : best;
      set_iss(mtag[addr], mdst[addr], mst[addr], msb[addr]);
      #2;
      chk("r_a1", 32'(alloc1), 32'(a1));
      chk("r_a2", 32'(alloc2), 32'(a2));
      chk("r_st", 32'(alloc_stall), 32'(st));
      if (a1) chk("r_e1", 32'(allocent1), fl0);
      if (a2) chk("r_e2", 32'(allocent2), e2);
      chk("r_go", 32'(issue_go), 32'(go));
      chk("r_addr", 32'(issueaddr), addr);
      chk("r_adv", 32'(pipe_adv), 32'(adv));
      chk("r_wbreq", 32'(wb_req), 32'(ewb));
      chk("r_wbtag", 32'(wb_rrftag), etag);
      edge_();

      nq.delete();
      foreach (fl_q[k]) begin
        o = fl_q[k];
        if (prmiss && o.sb && (o.stg & specfixtag) != 0) continue;
        if (!prmiss && prsuccess && o.stg == prtag) o.sb = 0;
        if (adv) begin
          if (o.pos == L) continue;
          o.pos++;
        end
        nq.push_back(o);
      end
      if (go) begin
        o.tag = mtag[addr]; o.dst = mdst[addr]; o.stg = mst[addr];
        o.sb  = msb[addr] && !(prsuccess && mst[addr] == prtag);
        o.pos = 1;
        nq.push_back(o);
        mb[addr] = 0;
      end
      fl_q = nq;
      for (int e = 0; e < 2; e++) begin
        if (prmiss) begin
          if (mb[e] && msb[e] && (mst[e] & specfixtag) != 0) mb[e] = 0;
        end else if (prsuccess && mst[e] == prtag) begin
          msb[e] = 0;
        end
      end
      if (a1) newent(fl0);
      if (a2) newent(e2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_rs_sched.md
Name: mul_rs_sched

Overview:
- Allocation and issue scheduler for the two-entry multiplier reservation station.
- Dispatch side: chooses free entries for up to two new multiply ops per cycle and tracks their allocation age.
- Issue side: selects the oldest ready entry and launches it into a fully pipelined MUL_LAT-stage multiplier.
- Pipeline side: carries each op's tag and speculation state down a shadow pipe and holds a writeback request until the common-data-bus arbiter grants it.

Parameters:
- ENT_NUM, 2, number of RS entries; must equal the station's entry count.
- ENT_SEL, 1, entry index width, clog2(ENT_NUM).
- MUL_LAT, 3, multiplier pipeline depth in cycles; legal range 1..8.
- RRF_SEL, 6, rename-register tag width.
- SPECTAG_LEN, 5, one-hot speculation tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req1  in  1  dispatch slot 1 carries a mul op
- req2  in  1  dispatch slot 2 carries a mul op
- busyvec  in  ENT_NUM  station busy bits
- readyvec  in  ENT_NUM  station ready bits
- alloc1  out  1  write enable to station slot 1 (we1)
- alloc2  out  1  write enable to station slot 2 (we2)
- allocent1  out  ENT_SEL  entry for slot 1 (waddr1)
- allocent2  out  ENT_SEL  entry for slot 2 (waddr2)
- alloc_stall  out  1  dispatch must hold this cycle
- issue_go  out  1  clearbusy to station; op enters multiplier
- issueaddr  out  ENT_SEL  entry being issued
- iss_rrftag  in  RRF_SEL  station rrftag at issueaddr
- iss_dstval  in  1  station dstval at issueaddr
- iss_spectag  in  SPECTAG_LEN  station spectag at issueaddr
- iss_specbit  in  1  station specbit at issueaddr
- prmiss  in  1  branch mispredict
- prsuccess  in  1  branch resolved correct
- prtag  in  SPECTAG_LEN  resolved branch tag
- specfixtag  in  SPECTAG_LEN  mask of tags killed on prmiss
- pipe_adv  out  1  multiplier stage enable
- wb_req  out  1  final stage holds a valid op with dstval
- wb_rrftag  out  RRF_SEL  destination tag of final stage
- wb_grant  in  1  CDB arbiter grant

Behaviour:
- Reset: every output is 0; age matrix, stage valid bits, tags and specbits are cleared.
- Allocation is combinational from busyvec.
  - Free entries are taken lowest index first.
  - req1 only: slot 1 gets the lowest free entry.
  - req2 only: slot 2 gets the lowest free entry.
  - Both: slot 1 gets the lowest free entry, slot 2 the next free entry.
  - alloc_stall=1 when the number of free entries is below the number requested, or when prmiss or prsuccess is high (the station ignores writes during those cycles).
  - While alloc_stall=1, alloc1=alloc2=0; there is no partial allocation.
- Age matrix: older[i][j]=1 means entry i is older than entry j.
  - On allocation of entry e: clear older[e][*] and set older[*][e] for every entry already busy.
  - On dual allocation, allocent1 is older than allocent2.
  - On prmiss the matrix is kept, because the station retains its survivors.
- Issue:
  - Candidates are readyvec & busyvec. issueaddr is the candidate that is older than every other candidate; ties cannot occur.
  - issue_go = (any candidate) & pipe_adv & ~prmiss.
  - issueaddr is 0 when there is no candidate.
  - An entry being issued and an entry being allocated in the same cycle are always distinct, since allocation only takes non-busy entries.
- Pipeline:
  - Each stage holds valid, dstval, rrftag, spectag and specbit. Stage 0 loads the iss_* inputs when issue_go=1; otherwise it loads valid=0.
  - pipe_adv = ~(final.valid & final.dstval & ~wb_grant).
  - pipe_adv=0 freezes all stages and blocks issue.
  - Results leave the final stage on the cycle after it is presented with wb_grant=1; ops with dstval=0 leave without a request.
  - wb_req = final.valid & final.dstval. wb_rrftag is the final stage's tag, or 0 when invalid.
  - Latency: issue in cycle t gives wb_req in cycle t+MUL_LAT when there are no stalls.
- Speculation, applied to every stage including the stage being loaded:
  - prmiss: a stage with specbit=1 and (spectag & specfixtag)!=0 is invalidated. A killed final stage drops wb_req in the next cycle and releases the stall.
  - prsuccess: a stage with spectag==prtag has its specbit cleared.
  - prmiss and prsuccess together: prmiss wins.
- Reset mid-operation discards every in-flight op without a writeback.

Test Plan:
- Reset, busyvec=00, req1=req2=1 -> allocent1=0, allocent2=1, alloc1=alloc2=1, alloc_stall=0; the next cycle has no wb_req.
- busyvec=01, req1=req2=1 -> alloc_stall=1, alloc1=alloc2=0. Same with req2 only -> allocent2=1, alloc2=1.
- Entry 1 allocated before entry 0, then readyvec=11 -> issueaddr=1 first. After clearing and re-readying, entry 0 issues. wb_req with iss_rrftag=0x15 appears exactly 3 cycles after issue_go.
- Final stage valid with wb_grant=0 for 4 cycles while readyvec=01 -> pipe_adv=0, issue_go=0, wb_rrftag held. Grant arrives -> issue_go=1 in the same cycle, and the final stage is released on the next cycle.
- Op with spectag=00100, specbit=1 in stage 1; prmiss with specfixtag=00110 -> that stage is invalid next cycle and never raises wb_req. An op with spectag=01000 survives.
- prsuccess with prtag=00100 on an op with specbit=1 -> its specbit clears; a later prmiss with specfixtag=00100 does not kill it, and wb_req appears on schedule.
